// File: rtl/hazard_pkg.sv
// Package: hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   hazard_state_e  : controller state {RUN, MC_WAIT}
//   REG_ZERO        : architectural zero register index (never a hazard source)
//   mc_lat_legal()  : elaboration-time range check for the multicycle EX latency
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } hazard_state_e;

    localparam int REG_ZERO   = 0;
    localparam int MC_LAT_MIN = 2;
    localparam int MC_LAT_MAX = 15;

    function automatic bit mc_lat_legal(input int lat);
        return (lat >= MC_LAT_MIN) && (lat <= MC_LAT_MAX);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Module: hazard_perf_cnt
// Pair of saturating event counters for hazard statistics.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high; clears both counters
//   stall_inc    in   count one stall cycle
//   flush_inc    in   count one flush event
//   stall_cycles out  CNT_W stall-cycle count, holds at all-ones
//   flush_events out  CNT_W flush-event count, holds at all-ones
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_inc && (flush_events != '1)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Module: hazard_ctrl_unit
// Pipeline hazard controller beside the ID stage. Generates PC / IF/ID write
// enables and IF/ID, ID/EX flush/hold controls for load-use stalls, taken-branch
// flushes and multicycle (mult/div) EX occupancy. Outputs are combinational from
// the current state and inputs.
// Optional feature: define HAZ_PERF_EN to add saturating performance counters.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   id_rs, id_rt      source register indices of the instruction in ID
//   id_uses_rt        ID instruction reads rt
//   id_mc_op          ID instruction is a multicycle EX op
//   idex_mem_to_reg   instruction in EX is a load
//   idex_rt           destination of the load in EX
//   ex_branch_taken   EX resolved a taken branch/jump
//   pc_write          PC update enable
//   ifid_write        IF/ID update enable
//   ifid_flush        IF/ID clear to NOP
//   idex_flush        ID/EX clear to bubble
//   idex_hold         ID/EX retains contents
//   ex_busy           multicycle op in progress
//   stall_cycles      (HAZ_PERF_EN) cycles with pc_write low
//   flush_events      (HAZ_PERF_EN) cycles with ifid_flush high
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_mc_op,
    input  logic             idex_mem_to_reg,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             idex_hold,
    output logic             ex_busy
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`endif
);

    localparam int MC_CNT_W = $clog2(MC_LAT);

    if (!mc_lat_legal(MC_LAT)) begin : g_bad_mc_lat
        $error("hazard_ctrl_unit: MC_LAT must lie in 2..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl_unit: CNT_W must be at least 1");
    end

    hazard_state_e       state, state_nxt;
    logic [MC_CNT_W-1:0] mc_cnt, mc_cnt_nxt;
    logic                load_use;

    // The load's destination must be a real register and match a source the
    // ID instruction actually reads; rt only counts when the op reads it.
    assign load_use = idex_mem_to_reg
                   && (idex_rt != REG_W'(REG_ZERO))
                   && ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

    // NOTE: asynchronous reset with non-blocking updates; a reset mid-MC_WAIT
    // drops straight back to RUN without waiting for an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            mc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    // NOTE: every output and next-state value is defaulted first so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        idex_hold  = 1'b0;
        ex_busy    = 1'b0;

        unique case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    // Wrong-path instructions in IF/ID and ID are squashed;
                    // the front end keeps fetching from the branch target.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    // One bubble: the load leaves EX next cycle, clearing the hazard.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_mc_op) begin
                    // The mc op enters EX at this edge; it occupies EX for
                    // MC_LAT cycles, the first of which is this entry edge.
                    state_nxt  = MC_WAIT;
                    mc_cnt_nxt = MC_CNT_W'(MC_LAT - 1);
                end
            end

            MC_WAIT: begin
                // EX is holding the mc op, so no load or branch can be in EX.
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_hold  = 1'b1;
                ex_busy    = 1'b1;
                mc_cnt_nxt = mc_cnt - MC_CNT_W'(1);
                if (mc_cnt == MC_CNT_W'(1)) begin
                    state_nxt = RUN;
                end
            end

            default: begin
                state_nxt  = RUN;
                mc_cnt_nxt = '0;
            end
        endcase
    end

`ifdef HAZ_PERF_EN
    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk          (clk),
        .reset        (reset),
        .stall_inc    (~pc_write),
        .flush_inc    (ifid_flush),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Testbench: tb_hazard_ctrl_unit
// Directed scenarios followed by randomized traffic, checked against a
// cycle-level reference model of the hazard rules (remaining-busy-cycle count
// plus rule priority). With HAZ_PERF_EN defined, the performance counters of a
// default instance and a CNT_W=2 instance are checked as well.
module tb_hazard_ctrl_unit;

    localparam int REG_W  = 5;
    localparam int MC_LAT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, idex_rt;
    logic             id_uses_rt, id_mc_op, idex_mem_to_reg, ex_branch_taken;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, ex_busy;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int busy_left  = 0;   // remaining cycles in which EX is held by an mc op
    int stall_ref  = 0;
    int flush_ref  = 0;

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cycles, flush_events;
    logic [1:0]  stall_cycles_s, flush_events_s;
    logic        pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s, idex_hold_s, ex_busy_s;
`endif

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_W  (REG_W),
        .MC_LAT (MC_LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_mc_op        (id_mc_op),
        .idex_mem_to_reg (idex_mem_to_reg),
        .idex_rt         (idex_rt),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .idex_hold       (idex_hold),
        .ex_busy         (ex_busy)
`ifdef HAZ_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
`endif
    );

`ifdef HAZ_PERF_EN
    hazard_ctrl_unit #(
        .REG_W  (REG_W),
        .MC_LAT (MC_LAT),
        .CNT_W  (2)
    ) dut_sat (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_mc_op        (id_mc_op),
        .idex_mem_to_reg (idex_mem_to_reg),
        .idex_rt         (idex_rt),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write_s),
        .ifid_write      (ifid_write_s),
        .ifid_flush      (ifid_flush_s),
        .idex_flush      (idex_flush_s),
        .idex_hold       (idex_hold_s),
        .ex_busy         (ex_busy_s),
        .stall_cycles    (stall_cycles_s),
        .flush_events    (flush_events_s)
    );
`endif

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef HAZ_PERF_EN
        check({tag, ".stall_cycles"}, stall_cycles, 32'(stall_ref));
        check({tag, ".flush_events"}, flush_events, 32'(flush_ref));
        check({tag, ".stall_sat"}, 32'(stall_cycles_s), (stall_ref > 3) ? 32'd3 : 32'(stall_ref));
        check({tag, ".flush_sat"}, 32'(flush_events_s), (flush_ref > 3) ? 32'd3 : 32'(flush_ref));
`else
        checks = checks + 0;
`endif
    endtask

    task automatic set_idle();
        id_rs           = '0;
        id_rt           = '0;
        id_uses_rt      = 1'b0;
        id_mc_op        = 1'b0;
        idex_mem_to_reg = 1'b0;
        idex_rt         = '0;
        ex_branch_taken = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check the combinational
    // outputs against the model, then advance the model across the rising edge.
    task automatic step(input string tag,
                        input int rs, input int rt, input bit uses_rt, input bit mc,
                        input bit m2r, input int lrt, input bit br);
        bit lu;
        logic [5:0] exp_v, obs_v;
        @(negedge clk);
        id_rs           = REG_W'(rs);
        id_rt           = REG_W'(rt);
        id_uses_rt      = uses_rt;
        id_mc_op        = mc;
        idex_mem_to_reg = m2r;
        idex_rt         = REG_W'(lrt);
        ex_branch_taken = br;
        #1;
        lu = m2r && (lrt != 0) && ((lrt == rs) || (uses_rt && (lrt == rt)));
        // {pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, ex_busy}
        if (busy_left > 0)  exp_v = 6'b000011;
        else if (br)        exp_v = 6'b111100;
        else if (lu)        exp_v = 6'b000100;
        else                exp_v = 6'b110000;
        obs_v = {pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, ex_busy};
        check({tag, ".pc_write"},   32'(obs_v[5]), 32'(exp_v[5]));
        check({tag, ".ifid_write"}, 32'(obs_v[4]), 32'(exp_v[4]));
        check({tag, ".ifid_flush"}, 32'(obs_v[3]), 32'(exp_v[3]));
        check({tag, ".idex_flush"}, 32'(obs_v[2]), 32'(exp_v[2]));
        check({tag, ".idex_hold"},  32'(obs_v[1]), 32'(exp_v[1]));
        check({tag, ".ex_busy"},    32'(obs_v[0]), 32'(exp_v[0]));
        check({tag, ".hold_flush_excl"}, 32'(idex_hold & idex_flush), 32'd0);
        @(posedge clk);
        if (!exp_v[5]) stall_ref++;
        if (exp_v[3])  flush_ref++;
        if (busy_left > 0)           busy_left--;
        else if (!br && !lu && mc)   busy_left = MC_LAT - 1;
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        #1;
        check("reset.pc_write",   32'(pc_write),   32'd1);
        check("reset.ifid_write", 32'(ifid_write), 32'd1);
        check("reset.idex_flush", 32'(idex_flush), 32'd0);
        check("reset.ifid_flush", 32'(ifid_flush), 32'd0);
        check("reset.idex_hold",  32'(idex_hold),  32'd0);
        check("reset.ex_busy",    32'(ex_busy),    32'd0);
        check_perf("reset");
        @(negedge clk);
        reset = 1'b0;

        // 1 load-use + 1 mc op + 1 branch: 4 stall cycles, 1 flush
        step("lu_r8",      8, 0, 0, 0, 1, 8, 0);
        step("lu_r8_gone", 8, 0, 0, 0, 0, 8, 0);
        step("mc_enter",   1, 2, 1, 1, 0, 0, 0);
        step("mc_wait1",   3, 4, 0, 0, 0, 0, 0);
        step("mc_wait2",   3, 4, 0, 0, 0, 0, 0);
        step("mc_wait3",   3, 4, 0, 0, 0, 0, 0);
        step("mc_done",    3, 4, 0, 0, 0, 0, 0);
        step("branch",     5, 6, 1, 0, 0, 0, 1);
        check_perf("trio");

        // Register 0 and rt-usage rules
        step("lu_r0",         0, 0, 1, 0, 1, 0, 0);
        step("rt9_unused",    1, 9, 0, 0, 1, 9, 0);
        step("rt9_used",      1, 9, 1, 0, 1, 9, 0);
        // Priority: branch over load-use, load-use over mc entry, branch over mc entry
        step("br_over_lu",    7, 0, 0, 0, 1, 7, 1);
        step("lu_over_mc",    7, 0, 0, 1, 1, 7, 0);
        step("mc_represent",  7, 0, 0, 1, 0, 0, 0);
        step("mcw_ignore_lu", 7, 0, 0, 0, 1, 7, 0);
        step("mcw_ignore_br", 7, 0, 0, 0, 0, 0, 1);
        step("mcw_last",      7, 0, 0, 1, 0, 0, 0);
        step("run_again",     7, 0, 0, 0, 0, 0, 0);
        step("br_over_mc",    7, 0, 0, 1, 0, 0, 1);
        step("after_br_mc",   7, 0, 0, 0, 0, 0, 0);

        // Reset in MC_WAIT with two cycles left aborts to RUN at once
        step("rst_mc_enter", 1, 1, 0, 1, 0, 0, 0);
        step("rst_mc_wait",  1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        #1;
        check("midrst.pc_write",  32'(pc_write),  32'd1);
        check("midrst.ex_busy",   32'(ex_busy),   32'd0);
        check("midrst.idex_hold", 32'(idex_hold), 32'd0);
        busy_left = 0;
        stall_ref = 0;
        flush_ref = 0;
        check_perf("midrst");
        #2;
        reset = 1'b0;
        step("midrst_run", 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic on a small register set to provoke frequent matches
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), ($urandom_range(0, 9) < 2),
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 1));
        end
        check_perf("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
